// File: rtl/spi_host_arbiter.sv
// Round-robin, transaction-granular arbiter sharing one SPI host byte port between two requesters.
// Optional forced release of stalled transactions when SPI_ARB_TIMEOUT_EN is defined.
module spi_host_arbiter #(
   parameter int unsigned DataWidth     = 8,
   parameter int unsigned CsGapCycles   = 2,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_sys_i,
   input  logic                 req0_valid_i,
   input  logic [DataWidth-1:0] req0_data_i,
   input  logic                 req0_last_i,
   output logic                 req0_ready_o,
   input  logic                 req1_valid_i,
   input  logic [DataWidth-1:0] req1_data_i,
   input  logic                 req1_last_i,
   output logic                 req1_ready_o,
   output logic                 host_valid_o,
   output logic [DataWidth-1:0] host_data_o,
   input  logic                 host_ready_i,
   output logic                 cs_n_o,
   output logic [1:0]           grant_o,
   output logic                 timeout_o
);

   localparam int unsigned GapW = (CsGapCycles < 2) ? 1 : $clog2(CsGapCycles + 1);

   if (CsGapCycles < 1) begin : g_bad_gap
      $error("CsGapCycles must be at least 1");
   end
   if (TimeoutCycles < 1) begin : g_bad_tmo
      $error("TimeoutCycles must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
   logic                own_valid, own_last, xfer, tmo_fire;
   logic [DataWidth-1:0] own_data;

   always_comb begin
      own_valid = owner_q ? req1_valid_i : req0_valid_i;
      own_last  = owner_q ? req1_last_i  : req0_last_i;
      own_data  = owner_q ? req1_data_i  : req0_data_i;
   end

   assign xfer = (state_q == ACTIVE) && own_valid && host_ready_i;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

   logic [TmoW-1:0] tmo_cnt_q;

   assign tmo_fire = (state_q == ACTIVE) && (tmo_cnt_q == TmoW'(TimeoutCycles));

   // Counts consecutive owner-idle cycles; any valid cycle or leaving ACTIVE restarts it.
   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ACTIVE) && !own_valid && !tmo_fire) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif

   assign timeout_o = tmo_fire;

   always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
      if (rst_sys_i) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      gap_cnt_d    = gap_cnt_q;
      host_valid_o = 1'b0;
      host_data_o  = '0;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            gap_cnt_d = '0;
            if (req0_valid_i && req1_valid_i) begin
               owner_d = !last_owner_q;
            end else if (req1_valid_i) begin
               owner_d = 1'b1;
            end else begin
               owner_d = 1'b0;
            end
            if (req0_valid_i || req1_valid_i) begin
               state_d = ACTIVE;
            end
         end

         ACTIVE: begin
            host_valid_o = own_valid;
            host_data_o  = own_valid ? own_data : '0;
            req0_ready_o = !owner_q && host_ready_i;
            req1_ready_o =  owner_q && host_ready_i;
            if ((xfer && own_last) || tmo_fire) begin
               state_d      = GAP;
               last_owner_d = owner_q;
               gap_cnt_d    = '0;
            end
         end

         GAP: begin
            if (gap_cnt_q == GapW'(CsGapCycles - 1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Decoded straight from state flops so chip-select follows async reset immediately.
   assign cs_n_o  = (state_q != ACTIVE);
   assign grant_o = (state_q != ACTIVE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: doc/spi_host_arbiter.md
# spi_host_arbiter

Shares the demo system's single SPI host byte interface (driving SPI_TX/SPI_SCK) between two requesters, e.g. a core-side register interface and an autonomous display refresher. Grants whole transactions, framed by a `last` flag, with round-robin fairness. Drives an active-low chip-select that spans each granted transaction and enforces a minimum deselect gap between transactions. Sits between the requesters and the SPI host inside `ibex_demo_system`.

## Interface
Parameters:
- `DataWidth`, 8: byte width of the request and host data.
- `CsGapCycles`, 2: cycles `cs_n_o` stays high after a transaction ends. Must be at least 1.
- `TimeoutCycles`, 256: idle cycles allowed inside a granted transaction before forced release. Used only with `SPI_ARB_TIMEOUT_EN`. Must be at least 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk_sys_i`  in  1  system clock.
- `rst_sys_i`  in  1  asynchronous active-high reset.
- `req0_valid_i`  in  1  requester 0 has a byte.
- `req0_data_i`  in  DataWidth  requester 0 byte.
- `req0_last_i`  in  1  final byte of requester 0's transaction.
- `req0_ready_o`  out  1  requester 0 byte accepted.
- `req1_valid_i`, `req1_data_i`, `req1_last_i`, `req1_ready_o`: same as above, for requester 1.
- `host_valid_o`  out  1  byte to the SPI host.
- `host_data_o`  out  DataWidth  byte to the SPI host.
- `host_ready_i`  in  1  SPI host accepts the byte.
- `cs_n_o`  out  1  chip-select, active low.
- `grant_o`  out  2  one-hot current owner; 0 when no owner.
- `timeout_o`  out  1  one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, ACTIVE, GAP. Registers: `owner` (1 bit), `last_owner` (1 bit), gap counter, timeout counter.
- **IDLE**
  - If any `reqN_valid_i` is high, go to ACTIVE next cycle and latch `owner`.
  - With a single requester, that requester is granted.
  - With both requesting, the grant goes to `!last_owner`.
- **ACTIVE**
  - `cs_n_o` = 0 and `grant_o[owner]` = 1.
  - Host outputs are combinational pass-through from the owner: `host_valid_o` = owner valid, `host_data_o` = owner data.
  - Owner `ready_o` = `host_ready_i`. The non-owner `ready_o` = 0.
  - A transfer occurs when `host_valid_o` and `host_ready_i` are both high.
  - A transfer with owner `last` = 1 moves the FSM to GAP and sets `last_owner` = `owner`.
- **GAP**
  - `cs_n_o` = 1, `grant_o` = 0, `host_valid_o` = 0, all `ready_o` = 0.
  - Lasts exactly `CsGapCycles` cycles, then IDLE.
- A non-owner's request is ignored until IDLE. No preemption.
- `host_data_o` = 0 whenever `host_valid_o` = 0.
- Reset values:
  - State IDLE, `last_owner` = 1 (requester 0 wins the first tie), counters 0.
  - `cs_n_o` = 1, `grant_o` = 0, `host_valid_o` = 0, `host_data_o` = 0, both `ready_o` = 0, `timeout_o` = 0.
- Reset asserted mid-ACTIVE: `cs_n_o` rises immediately (asynchronously). No GAP is inserted and any partial transaction is abandoned.

## Timing
- A request arriving in IDLE at cycle N gives `cs_n_o` = 0 and `grant_o` valid at N+1. The earliest transfer is at N+1.
- `cs_n_o` and `grant_o` are registered (decoded from state flops). Data, valid and ready paths are combinational.
- A `last` transfer at cycle M gives `cs_n_o` = 1 over M+1 .. M+CsGapCycles. IDLE is reached at M+CsGapCycles+1, and the next grant at M+CsGapCycles+2 at the earliest.
- Back-to-back transactions from the same requester still pass through GAP.
- `host_ready_i` high while owner valid is low: no transfer, no state change.

## Configuration
- Macro: `SPI_ARB_TIMEOUT_EN`.
- **Defined:**
  - In ACTIVE, the timeout counter increments each cycle the owner's valid is low and clears on any cycle the owner's valid is high.
  - When the counter reaches `TimeoutCycles`, go to GAP without waiting for `last`.
  - `timeout_o` = 1 for that one cycle and `last_owner` = `owner`.
- **Not defined:** the counter is absent, `timeout_o` is tied to 0, and ACTIVE is left only by a `last` transfer.

## Test plan
- **Reset defaults:** assert `rst_sys_i` mid-simulation with no clock edge -> `cs_n_o` = 1, `grant_o` = 0, `host_valid_o` = 0, both `ready_o` = 0, with no clock edge needed.
- **Single transaction:** req0 sends 0xA5, 0x3C (last), `host_ready_i` = 1 -> `cs_n_o` low at N+1, host sees 0xA5 then 0x3C, `cs_n_o` high for exactly 2 cycles, `grant_o` = 2'b01 throughout ACTIVE.
- **Simultaneous requests from reset:** both valid at cycle N -> req0 granted first. After req0's last plus the gap, req1 is granted. A repeated tie then goes to req0.
- **Backpressure:** `host_ready_i` low for 5 cycles in ACTIVE -> owner `ready_o` = 0, `host_data_o` held stable, no transfers, state stays ACTIVE.
- **Timeout (macro defined, `TimeoutCycles` = 4):** req1 sends 0x11 without last, then drops valid -> after 4 idle cycles, `timeout_o` pulses once and `cs_n_o` rises. Without the macro, ACTIVE persists indefinitely.
- **Async reset mid-transaction:** reset after the first byte of a 3-byte req0 transaction -> `cs_n_o` = 1 immediately. After release, a new req1 request is granted with `grant_o` = 2'b10 (with `last_owner` back at 1, req0 would still win a tie).
